// File: rtl/rf_pkg.sv
// Shared definitions for the parametrised register file: operation codes and
// a constant-evaluable log2 used to size the read-select ports.
package rf_pkg;

    localparam logic [2:0] FS_HOLD  = 3'b000;
    localparam logic [2:0] FS_LOAD  = 3'b001;
    localparam logic [2:0] FS_CLEAR = 3'b010;
    localparam logic [2:0] FS_INC   = 3'b011;
    localparam logic [2:0] FS_DEC   = 3'b100;
    localparam logic [2:0] FS_SHL   = 3'b101;
    localparam logic [2:0] FS_SHR   = 3'b110;
    localparam logic [2:0] FS_ROL   = 3'b111;

    // Smallest r with 2**r >= n; at least 1 so a select port always exists.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rf_cell.sv
// One WIDTH-bit register of the file. Q_next is the value this register takes
// at the next edge when not in reset; evt flags a wrap, saturation or a 1 shifted out.
module rf_cell
    import rf_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SAT_MODE = 0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             en,
    input  logic [2:0]       FunSel,
    input  logic [WIDTH-1:0] Load,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_next,
    output logic             evt
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam bit               SAT      = (SAT_MODE != 0);

    always_comb begin
        Q_next = Q;
        evt    = 1'b0;
        if (en) begin
            case (FunSel)
                FS_LOAD:  Q_next = Load;
                FS_CLEAR: Q_next = '0;
                FS_INC: begin
                    if (Q == ALL_ONES) begin
                        evt    = 1'b1;
                        Q_next = SAT ? ALL_ONES : '0;
                    end else begin
                        Q_next = Q + ONE;
                    end
                end
                FS_DEC: begin
                    if (Q == '0) begin
                        evt    = 1'b1;
                        Q_next = SAT ? '0 : ALL_ONES;
                    end else begin
                        Q_next = Q - ONE;
                    end
                end
                FS_SHL: begin
                    evt    = Q[WIDTH-1];
                    Q_next = {Q[WIDTH-2:0], 1'b0};
                end
                FS_SHR: begin
                    evt    = Q[0];
                    Q_next = {1'b0, Q[WIDTH-1:1]};
                end
                // Rotation never loses a bit, so it raises no event.
                FS_ROL:  Q_next = {Q[WIDTH-2:0], Q[WIDTH-1]};
                default: Q_next = Q;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) Q <= '0;
        else        Q <= Q_next;
    end

endmodule

// File: rtl/param_reg_file.sv
// Parametrised register file: NUM_REGS cells sharing one operation code, a
// registered wrap/saturation/shift-out flag and two read ports with optional forwarding.
module param_reg_file
    import rf_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 8,
    parameter int SAT_MODE = 0,
    parameter int BYPASS   = 0,
    localparam int SEL_W   = clog2(NUM_REGS)
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [WIDTH-1:0]    Load,
    input  logic [NUM_REGS-1:0] RSel,
    input  logic [2:0]          FunSel,
    input  logic [SEL_W-1:0]    OutASel,
    input  logic [SEL_W-1:0]    OutBSel,
    output logic [WIDTH-1:0]    OutA,
    output logic [WIDTH-1:0]    OutB,
    output logic                Wrap
);

    logic [WIDTH-1:0]    cell_q    [NUM_REGS];
    logic [WIDTH-1:0]    cell_next [NUM_REGS];
    logic [NUM_REGS-1:0] cell_evt;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        rf_cell #(
            .WIDTH    (WIDTH),
            .SAT_MODE (SAT_MODE)
        ) u_cell (
            .Clock  (Clock),
            .Reset  (Reset),
            .en     (RSel[i]),
            .FunSel (FunSel),
            .Load   (Load),
            .Q      (cell_q[i]),
            .Q_next (cell_next[i]),
            .evt    (cell_evt[i])
        );
    end

    // Unselected cells and non-event codes report 0, so a plain OR suffices.
    always_ff @(posedge Clock) begin
        if (!Reset) Wrap <= 1'b0;
        else        Wrap <= |cell_evt;
    end

    logic fwd_a;
    logic fwd_b;

    always_comb begin
        fwd_a = (BYPASS != 0) && RSel[OutASel] && (FunSel != FS_HOLD);
        fwd_b = (BYPASS != 0) && RSel[OutBSel] && (FunSel != FS_HOLD);
        OutA  = fwd_a ? cell_next[OutASel] : cell_q[OutASel];
        OutB  = fwd_b ? cell_next[OutBSel] : cell_q[OutBSel];
    end

endmodule

// File: tb/tb_param_reg_file.sv
// Bench for param_reg_file: one wrap/no-bypass and one saturate/bypass instance
// driven in lockstep and scored against an arithmetic model of the register file.
module tb_param_reg_file;

    localparam int W  = 8;
    localparam int N  = 8;
    localparam int SW = 3;
    localparam int MAXV = (1 << W) - 1;

    // ---------------- clock / reset ----------------
    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic [W-1:0]  Load = '0;
    logic [N-1:0]  RSel = '0;
    logic [2:0]    FunSel = 3'b000;
    logic [SW-1:0] OutASel = '0;
    logic [SW-1:0] OutBSel = '0;

    always #5 Clock = ~Clock;

    logic [W-1:0] out_a0, out_b0, out_a1, out_b1;
    logic         wrap0, wrap1;

    param_reg_file #(.WIDTH(W), .NUM_REGS(N), .SAT_MODE(0), .BYPASS(0)) dut_wrap (
        .Clock(Clock), .Reset(Reset), .Load(Load), .RSel(RSel), .FunSel(FunSel),
        .OutASel(OutASel), .OutBSel(OutBSel), .OutA(out_a0), .OutB(out_b0), .Wrap(wrap0)
    );

    param_reg_file #(.WIDTH(W), .NUM_REGS(N), .SAT_MODE(1), .BYPASS(1)) dut_sat (
        .Clock(Clock), .Reset(Reset), .Load(Load), .RSel(RSel), .FunSel(FunSel),
        .OutASel(OutASel), .OutBSel(OutBSel), .OutA(out_a1), .OutB(out_b1), .Wrap(wrap1)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic         chk_byp;
        logic [W-1:0] a0;
        logic [W-1:0] b0;
        logic         w0;
        logic [W-1:0] a1;
        logic [W-1:0] b1;
        logic         w1;
    } exp_t;

    exp_t exp_q[$];

    logic [W-1:0] m_wrap_regs [N];
    logic [W-1:0] m_sat_regs  [N];
    logic         m_wrap_flag;
    logic         m_sat_flag;
    bit           model_known = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void ref_op(input logic [W-1:0] r, input logic [2:0] fs,
                                   input logic [W-1:0] ld, input bit sat,
                                   output logic [W-1:0] nv, output logic ev);
        int v;
        v  = int'(r);
        ev = 1'b0;
        nv = r;
        case (fs)
            3'd1: nv = ld;
            3'd2: nv = '0;
            3'd3: if (v == MAXV) begin ev = 1'b1; nv = sat ? r : W'(0); end
                  else nv = W'(v + 1);
            3'd4: if (v == 0) begin ev = 1'b1; nv = sat ? r : W'(MAXV); end
                  else nv = W'(v - 1);
            3'd5: begin ev = (v >= (1 << (W - 1))); nv = W'(v * 2); end
            3'd6: begin ev = (v % 2 == 1); nv = W'(v / 2); end
            3'd7: nv = W'((v * 2) + (v / (1 << (W - 1))));
            default: nv = r;
        endcase
    endfunction

    function automatic logic [W-1:0] read_port(input logic [W-1:0] regs [N], input int idx,
                                               input bit byp, input bit sat,
                                               input logic [N-1:0] rs, input logic [2:0] fs,
                                               input logic [W-1:0] ld);
        logic [W-1:0] nv;
        logic         ev;
        if (byp && rs[idx] && fs != 3'd0) begin
            ref_op(regs[idx], fs, ld, sat, nv, ev);
            return nv;
        end
        return regs[idx];
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input bit rst_n, input logic [N-1:0] rs, input logic [2:0] fs,
                         input logic [W-1:0] ld, input int as, input int bs);
        exp_t         e;
        logic [W-1:0] nv;
        logic         ev;
        logic         any0, any1;
        @(posedge Clock);
        #1;
        Reset   = rst_n;
        RSel    = rs;
        FunSel  = fs;
        Load    = ld;
        OutASel = SW'(as);
        OutBSel = SW'(bs);
        if (model_known) begin
            // Forwarded reads during a reset cycle are left unscored.
            e.chk_byp = rst_n;
            e.a0 = read_port(m_wrap_regs, as, 1'b0, 1'b0, rs, fs, ld);
            e.b0 = read_port(m_wrap_regs, bs, 1'b0, 1'b0, rs, fs, ld);
            e.w0 = m_wrap_flag;
            e.a1 = read_port(m_sat_regs, as, 1'b1, 1'b1, rs, fs, ld);
            e.b1 = read_port(m_sat_regs, bs, 1'b1, 1'b1, rs, fs, ld);
            e.w1 = m_sat_flag;
            exp_q.push_back(e);
        end
        any0 = 1'b0;
        any1 = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                m_wrap_regs[i] = '0;
                m_sat_regs[i]  = '0;
            end else if (rs[i]) begin
                ref_op(m_wrap_regs[i], fs, ld, 1'b0, nv, ev);
                m_wrap_regs[i] = nv;
                any0 |= ev;
                ref_op(m_sat_regs[i], fs, ld, 1'b1, nv, ev);
                m_sat_regs[i] = nv;
                any1 |= ev;
            end
        end
        m_wrap_flag = rst_n ? any0 : 1'b0;
        m_sat_flag  = rst_n ? any1 : 1'b0;
        model_known = 1'b1;
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wrap_outa", out_a0, e.a0);
                check("wrap_outb", out_b0, e.b0);
                check("wrap_flag", W'(wrap0), W'(e.w0));
                check("sat_flag",  W'(wrap1), W'(e.w1));
                if (e.chk_byp) begin
                    check("sat_outa", out_a1, e.a1);
                    check("sat_outb", out_b1, e.b1);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int wait_cycles;
        logic [W-1:0] ld;
        drive(0, '0, 3'd0, '0, 0, 0);
        drive(0, '0, 3'd0, '0, 0, 1);
        // Reset after loading 0x55 everywhere, with an INC also requested.
        drive(1, 8'hFF, 3'd1, 8'h55, 0, 7);
        drive(0, 8'hFF, 3'd3, 8'h00, 0, 7);
        drive(1, 8'h00, 3'd0, 8'h00, 0, 7);
        // Multi-select load.
        drive(1, 8'b0000_0101, 3'd1, 8'hA3, 0, 2);
        drive(1, 8'h00, 3'd0, 8'h00, 0, 2);
        drive(1, 8'h00, 3'd0, 8'h00, 1, 2);
        // R3 increments past all-ones.
        drive(1, 8'h08, 3'd1, 8'hFF, 3, 3);
        drive(1, 8'h08, 3'd3, 8'h00, 3, 3);
        drive(1, 8'h00, 3'd0, 8'h00, 3, 3);
        drive(1, 8'h00, 3'd0, 8'h00, 3, 3);
        // R4 boundaries in both directions.
        drive(1, 8'h10, 3'd1, 8'h00, 4, 4);
        drive(1, 8'h10, 3'd4, 8'h00, 4, 4);
        drive(1, 8'h00, 3'd0, 8'h00, 4, 4);
        drive(1, 8'h10, 3'd1, 8'hFF, 4, 4);
        drive(1, 8'h10, 3'd3, 8'h00, 4, 4);
        drive(1, 8'h00, 3'd0, 8'h00, 4, 4);
        // R5 shifts and rotate.
        drive(1, 8'h20, 3'd1, 8'h81, 5, 5);
        drive(1, 8'h20, 3'd5, 8'h00, 5, 5);
        drive(1, 8'h00, 3'd0, 8'h00, 5, 5);
        drive(1, 8'h20, 3'd1, 8'h81, 5, 5);
        drive(1, 8'h20, 3'd7, 8'h00, 5, 5);
        drive(1, 8'h00, 3'd0, 8'h00, 5, 5);
        drive(1, 8'h20, 3'd1, 8'h01, 5, 5);
        drive(1, 8'h20, 3'd6, 8'h00, 5, 5);
        drive(1, 8'h00, 3'd0, 8'h00, 5, 5);
        // R6 forwarding vs. registered read.
        drive(1, 8'h40, 3'd1, 8'h10, 6, 6);
        drive(1, 8'h40, 3'd3, 8'h00, 6, 0);
        drive(1, 8'h00, 3'd0, 8'h00, 6, 0);
        // Random traffic, biased toward boundary load values.
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0:       ld = '0;
                1:       ld = '1;
                default: ld = W'($urandom);
            endcase
            drive($urandom_range(0, 40) != 0, N'($urandom), 3'($urandom_range(0, 7)), ld,
                  $urandom_range(0, N - 1), $urandom_range(0, N - 1));
        end
        drive(1, '0, 3'd0, '0, 0, 1);
        drive(1, '0, 3'd0, '0, 2, 3);
        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 20) begin
            @(posedge Clock);
            wait_cycles++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
